// File: rtl/ldl_pkg.sv
// Shared types and fixed-point constants for the LDL^T solve stage.
package ldl_pkg;

    localparam int unsigned LdlQ     = 24;
    localparam int unsigned LdlWidth = 32;

    // 1.0 in the signed Q-format used throughout the Kalman-gain datapath
    localparam logic [LdlWidth-1:0] LdlOne = LdlWidth'(1) <<< LdlQ;

    typedef enum logic [3:0] {
        IDLE,
        F_ROW,
        F_BRD,
        F_LADDR,
        F_MUL,
        F_ACC,
        F_SAVE,
        D_ADDR,
        D_REQ,
        D_WAIT,
        B_ROW,
        B_LADDR,
        B_MUL,
        B_ACC,
        B_SAVE,
        FINISH
    } ldl_state_e;

endpackage

// File: rtl/ldl_solve.sv
// Solves L*D*L^T x = b: forward substitution, diagonal scaling through the
// shared external divider, then back substitution. y[] is reused in place
// for y, z and finally x; x is streamed out from x[N-1] down to x[0].
module ldl_solve
    import ldl_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned Q     = LdlQ,
    parameter int unsigned WIDTH = LdlWidth,
    localparam int unsigned LAW  = $clog2(N * N),
    localparam int unsigned VW   = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [LAW-1:0]       l_addr,
    input  logic [WIDTH-1:0]     l_rdata,
    output logic [VW-1:0]        d_addr,
    input  logic [WIDTH-1:0]     d_rdata,
    output logic [VW-1:0]        b_addr,
    input  logic [WIDTH-1:0]     b_rdata,
    output logic                 div_start,
    output logic [2*WIDTH-1:0]   div_num,
    output logic [WIDTH-1:0]     div_den,
    input  logic [2*WIDTH-1:0]   div_quot,
    input  logic                 div_done,
    output logic                 x_we,
    output logic [VW-1:0]        x_addr,
    output logic [WIDTH-1:0]     x_wdata
);

    // Row/column counters must be able to hold N (j runs one past the last column)
    localparam int unsigned IW = $clog2(N + 1);

    ldl_state_e state_q, state_d;

    logic [WIDTH-1:0]          y_q [N];
    logic [WIDTH-1:0]          y_d [N];
    logic signed [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]          acc_q, acc_d;
    logic [IW-1:0]             i_q, i_d, j_q, j_d;
    logic                      err_q, err_d;
    logic                      zero_q, zero_d;

    logic [VW-1:0]        i_idx, j_idx;
    logic                 i_last;
    logic [WIDTH-1:0]     mac_term;
    logic [2*WIDTH-1:0]   num_ext;
    logic                 unused_quot_hi;

    assign i_idx    = i_q[VW-1:0];
    assign j_idx    = j_q[VW-1:0];
    assign i_last   = (i_q == IW'(N - 1));
    // Arithmetic shift then wrap-around truncation; no saturation by design
    assign mac_term = WIDTH'(prod_q >>> Q);
    assign num_ext  = {{WIDTH{y_q[i_idx][WIDTH-1]}}, y_q[i_idx]} <<< Q;
    assign unused_quot_hi = ^div_quot[2*WIDTH-1:WIDTH];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing of the three solve phases
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = F_ROW;
            F_ROW:   state_d = F_BRD;
            F_BRD:   state_d = (i_q == '0) ? F_SAVE : F_LADDR;
            F_LADDR: state_d = F_MUL;
            F_MUL:   state_d = F_ACC;
            F_ACC:   state_d = ((j_q + IW'(1)) < i_q) ? F_LADDR : F_SAVE;
            F_SAVE:  state_d = i_last ? D_ADDR : F_ROW;
            D_ADDR:  state_d = D_REQ;
            D_REQ:   state_d = D_WAIT;
            D_WAIT:  if (div_done) state_d = i_last ? B_ROW : D_ADDR;
            B_ROW:   state_d = i_last ? B_SAVE : B_LADDR;
            B_LADDR: state_d = B_MUL;
            B_MUL:   state_d = B_ACC;
            B_ACC:   state_d = ((32'(j_q) + 32'd1) < N) ? B_LADDR : B_SAVE;
            B_SAVE:  state_d = (i_q == '0) ? FINISH : B_ROW;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(N); k++) begin
                y_q[k] <= '0;
            end
            prod_q <= '0;
            acc_q  <= '0;
            i_q    <= '0;
            j_q    <= '0;
            err_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            prod_q <= prod_d;
            acc_q  <= acc_d;
            i_q    <= i_d;
            j_q    <= j_d;
            err_q  <= err_d;
            zero_q <= zero_d;
        end
    end

    // Datapath next-state: MAC steps, saves and divider result capture
    always_comb begin
        y_d    = y_q;
        prod_d = prod_q;
        acc_d  = acc_q;
        i_d    = i_q;
        j_d    = j_q;
        err_d  = err_q;
        zero_d = zero_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    i_d   = '0;
                    j_d   = '0;
                end
            end
            F_BRD: begin
                acc_d = b_rdata;
                j_d   = '0;
            end
            F_MUL, B_MUL: begin
                prod_d = $signed(l_rdata) * $signed(y_q[j_idx]);
            end
            F_ACC, B_ACC: begin
                acc_d = acc_q - mac_term;
                j_d   = j_q + IW'(1);
            end
            F_SAVE: begin
                y_d[i_idx] = acc_q;
                i_d        = i_last ? '0 : i_q + IW'(1);
            end
            D_REQ: begin
                // Divider is still kicked on a zero pivot; its answer is dropped
                zero_d = (d_rdata == '0);
                if (d_rdata == '0) begin
                    err_d = 1'b1;
                end
            end
            D_WAIT: begin
                if (div_done) begin
                    y_d[i_idx] = zero_q ? '0 : div_quot[WIDTH-1:0];
                    i_d        = i_last ? IW'(N - 1) : i_q + IW'(1);
                end
            end
            B_ROW: begin
                acc_d = y_q[i_idx];
                j_d   = i_q + IW'(1);
            end
            B_SAVE: begin
                y_d[i_idx] = acc_q;
                if (i_q != '0) begin
                    i_d = i_q - IW'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == FINISH);
        err       = err_q;
        l_addr    = '0;
        d_addr    = '0;
        b_addr    = '0;
        div_start = 1'b0;
        div_num   = '0;
        div_den   = '0;
        x_we      = 1'b0;
        x_addr    = '0;
        x_wdata   = '0;
        unique case (state_q)
            F_ROW:   b_addr = i_idx;
            F_LADDR: l_addr = LAW'(32'(i_q) * N + 32'(j_q));
            B_LADDR: l_addr = LAW'(32'(j_q) * N + 32'(i_q));
            D_ADDR:  d_addr = i_idx;
            D_REQ: begin
                div_start = 1'b1;
                div_num   = num_ext;
                div_den   = d_rdata;
            end
            B_SAVE: begin
                x_we    = 1'b1;
                x_addr  = i_idx;
                x_wdata = acc_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldl_solve.sv
// Randomized and directed bench for ldl_solve against a plain-arithmetic model.
module tb_ldl_solve;
    import ldl_pkg::*;

    localparam int N = 3;
    localparam int Q = 24;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, err;
    logic [3:0]    l_addr;
    logic [1:0]    d_addr, b_addr, x_addr;
    logic [W-1:0]  l_rdata, d_rdata, b_rdata;
    logic          div_start, div_done;
    logic [2*W-1:0] div_num, div_quot;
    logic [W-1:0]  div_den;
    logic          x_we;
    logic [W-1:0]  x_wdata;

    ldl_solve #(.N(N), .Q(Q), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .l_addr(l_addr), .l_rdata(l_rdata), .d_addr(d_addr), .d_rdata(d_rdata),
        .b_addr(b_addr), .b_rdata(b_rdata), .div_start(div_start), .div_num(div_num),
        .div_den(div_den), .div_quot(div_quot), .div_done(div_done),
        .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata)
    );

    always #5 clk = ~clk;

    int l_mem [N*N];
    int d_mem [N];
    int b_mem [N];
    int exp_x [N];

    // Synchronous RAMs, one-cycle read latency
    always @(posedge clk) begin
        l_rdata <= (int'(l_addr) < N*N) ? l_mem[l_addr] : 32'hBAD0_BAD0;
        d_rdata <= d_mem[d_addr];
        b_rdata <= b_mem[b_addr];
    end

    // Divider model: done pulse Ld cycles after the request cycle
    int            div_lat = 1;
    int            div_cnt = 0;
    logic [2*W-1:0] num_l;
    logic [W-1:0]  den_l;
    logic          stray = 1'b0;
    int            n_div_start = 0;
    longint        qv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 0;
        end else if (div_start) begin
            num_l   <= div_num;
            den_l   <= div_den;
            div_cnt <= div_lat;
            n_div_start <= n_div_start + 1;
        end else if (div_cnt > 0) begin
            div_cnt <= div_cnt - 1;
        end
    end

    always_comb begin
        if (den_l == '0) qv = 64'hA5A5_5A5A_1234_5678;
        else qv = $signed(num_l) / longint'($signed(den_l));
        div_quot = qv;
    end
    assign div_done = (div_cnt == 1) | stray;

    // Capture x writes away from the clock edge
    int        wq_addr [$];
    logic [W-1:0] wq_data [$];
    always @(negedge clk) begin
        if (x_we) begin
            wq_addr.push_back(int'(x_addr));
            wq_data.push_back(x_wdata);
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int mac_term(input int l, input int y);
        longint p = longint'(l) * longint'(y);
        return int'(p >>> Q);
    endfunction

    // Reference: textbook forward / diagonal / back substitution in integers
    task automatic ref_solve();
        int y [N];
        int acc;
        for (int i = 0; i < N; i++) begin
            acc = b_mem[i];
            for (int j = 0; j < i; j++) acc = acc - mac_term(l_mem[i*N+j], y[j]);
            y[i] = acc;
        end
        for (int i = 0; i < N; i++) begin
            if (d_mem[i] == 0) y[i] = 0;
            else y[i] = int'((longint'(y[i]) <<< Q) / longint'(d_mem[i]));
        end
        for (int i = N - 1; i >= 0; i--) begin
            acc = y[i];
            for (int j = i + 1; j < N; j++) acc = acc - mac_term(l_mem[j*N+i], y[j]);
            y[i] = acc;
        end
        exp_x = y;
    endtask

    function automatic int exp_done_cycle(input int ld);
        return 1 + (3*N + 3*N*(N-1)/2) + N*(2 + ld) + (2*N + 3*N*(N-1)/2);
    endfunction

    task automatic load_known(input bit neg, input int d1);
        l_mem = '{32'h0100_0000, 0, 0,
                  32'h0080_0000, 32'h0100_0000, 0,
                  32'h0040_0000, 32'h0080_0000, 32'h0100_0000};
        d_mem = '{32'h0200_0000, d1, 32'h0400_0000};
        b_mem = '{32'h0380_0000, 32'h0340_0000, 32'h05A0_0000};
        if (neg) for (int k = 0; k < N; k++) b_mem[k] = -b_mem[k];
    endtask

    task automatic run_op(input int ld, input bit noise, output int done_cyc);
        div_lat = ld;
        wq_addr.delete();
        wq_data.delete();
        n_div_start = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        done_cyc = -1;
        for (int c = 1; c <= 400; c++) begin
            if (c == 1) begin
                check_eq("busy_run", 64'(busy), 64'd1);
                check_eq("err_clr", 64'(err), 64'd0);
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            start = noise && (c == 5 || c == 20);
            stray = noise && (c == 3 || c == 45 || c == 48);
            @(posedge clk); #1;
        end
        start = 1'b0;
        stray = 1'b0;
        check_eq("done_cycle", 64'(done_cyc), 64'(exp_done_cycle(ld)));
        @(posedge clk); #1;
        check_eq("idle_after", {63'd0, busy | done}, 64'd0);
    endtask

    task automatic check_x(input string tag);
        check_eq({tag, "_nwr"}, 64'(wq_addr.size()), 64'(N));
        for (int k = 0; k < N && k < wq_addr.size(); k++) begin
            check_eq({tag, "_addr"}, 64'(wq_addr[k]), 64'(N - 1 - k));
            check_eq({tag, "_x"}, 64'(wq_data[k]), 64'(unsigned'(exp_x[N - 1 - k])));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int dc;
        int sz;
        for (int k = 0; k < N*N; k++) l_mem[k] = 0;
        for (int k = 0; k < N; k++) begin
            d_mem[k] = 0;
            b_mem[k] = 0;
        end
        #3;
        check_eq("rst_ctrl", {59'd0, busy, done, err, div_start, x_we}, 64'd0);
        check_eq("rst_addr", {52'd0, l_addr, d_addr, b_addr, x_addr}, 64'd0);
        #20 rst_n = 1'b1;

        // Identity system
        for (int k = 0; k < N*N; k++) l_mem[k] = (k % (N + 1) == 0) ? int'(LdlOne) : 0;
        d_mem = '{32'h0100_0000, 32'h0100_0000, 32'h0100_0000};
        b_mem = '{32'h0100_0000, 32'h0200_0000, 32'h0300_0000};
        exp_x = '{32'h0100_0000, 32'h0200_0000, 32'h0300_0000};
        run_op(1, 1'b0, dc);
        check_x("ident");
        check_eq("ident_err", 64'(err), 64'd0);

        // Known system, x = 1.0 everywhere
        load_known(1'b0, 32'h0100_0000);
        exp_x = '{32'h0100_0000, 32'h0100_0000, 32'h0100_0000};
        run_op(1, 1'b0, dc);
        check_x("known");

        // Negated b, x = -1.0 everywhere
        load_known(1'b1, 32'h0100_0000);
        exp_x = '{32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};
        run_op(1, 1'b0, dc);
        check_x("neg");

        // Zero pivot on D[1]
        load_known(1'b0, 0);
        ref_solve();
        run_op(2, 1'b0, dc);
        check_x("zpiv");
        check_eq("zpiv_err", 64'(err), 64'd1);
        check_eq("zpiv_ndiv", 64'(n_div_start), 64'(N));

        // Slow divider with stray start / div_done pulses (err must clear on start)
        load_known(1'b0, 32'h0100_0000);
        exp_x = '{32'h0100_0000, 32'h0100_0000, 32'h0100_0000};
        run_op(5, 1'b1, dc);
        check_x("slow");
        check_eq("slow_err", 64'(err), 64'd0);

        // Randomized systems against the model
        for (int t = 0; t < 6; t++) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (r == c) l_mem[r*N+c] = int'(LdlOne);
                    else if (c < r) l_mem[r*N+c] = int'($urandom_range(0, 32'h0200_0000)) - 32'h0100_0000;
                    else l_mem[r*N+c] = int'($urandom);
                end
                d_mem[r] = int'($urandom_range(32'h0080_0000, 32'h0280_0000));
                if ($urandom_range(0, 1) == 1) d_mem[r] = -d_mem[r];
                b_mem[r] = int'($urandom_range(0, 32'h0800_0000)) - 32'h0400_0000;
            end
            ref_solve();
            run_op(int'($urandom_range(1, 4)), 1'b0, dc);
            check_x("rand");
        end

        // Reset during back substitution, then a clean rerun
        load_known(1'b0, 32'h0100_0000);
        div_lat = 1;
        wq_addr.delete();
        wq_data.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c < 35; c++) begin
            @(posedge clk); #1;
        end
        sz = wq_addr.size();
        rst_n = 1'b0;
        #1;
        check_eq("mrst_ctrl", {59'd0, busy, done, err, div_start, x_we}, 64'd0);
        check_eq("mrst_addr", {52'd0, l_addr, d_addr, b_addr, x_addr}, 64'd0);
        check_eq("mrst_data", {31'd0, |div_num, |div_den, x_wdata}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("mrst_nowr", 64'(wq_addr.size()), 64'(sz));
        rst_n = 1'b1;
        exp_x = '{32'h0100_0000, 32'h0100_0000, 32'h0100_0000};
        run_op(1, 1'b0, dc);
        check_x("after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
